// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - UART command-frame initiator for the registered ALU
// Parses 0xCC/A/B/FUN frames, fires ALU_EN once, and returns the result byte to TX.
module alu_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  input  logic                  TX_BUSY,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  FRAME_ERR
);

  typedef enum logic [2:0] {
    IDLE, GET_A, GET_B, GET_FUN, ALU_REQ, ALU_WAIT, TX_SEND
  } state_t;

  localparam logic [7:0] HEADER   = 8'hCC;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic [7:0]            txd_q, txd_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  err_q, err_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      txd_q    <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fun_q    <= fun_d;
      txd_q    <= txd_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      tx_vld_q <= tx_vld_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    fun_d    = fun_q;
    txd_d    = txd_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    tx_vld_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == HEADER) state_d = GET_A;
          else                     err_d   = 1'b1;
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          a_d     = RX_P_DATA;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          b_d     = RX_P_DATA;
          state_d = GET_FUN;
        end
      end
      GET_FUN: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA[7:4] == 4'h0) begin
            fun_d   = RX_P_DATA[FUN_WIDTH-1:0];
            en_d    = 1'b1;
            state_d = ALU_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ALU_REQ: begin
        err_d   = RX_D_VLD;
        cnt_d   = '0;
        state_d = ALU_WAIT;
      end
      ALU_WAIT: begin
        err_d = RX_D_VLD;
        if (ALU_OUT_VALID) begin
          txd_d = ALU_OUT;
          // Send straight from the capture edge when TX is free to meet 3-cycle latency.
          if (!TX_BUSY) begin
            tx_vld_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = TX_SEND;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      TX_SEND: begin
        err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_vld_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_FUN   = fun_q;
  assign ALU_EN    = en_q;
  assign TX_P_DATA = txd_q;
  assign TX_D_VLD  = tx_vld_q;
  assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - directed self-checking bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] ALU_A, ALU_B;
  logic [3:0] ALU_FUN;
  logic       ALU_EN;
  logic [7:0] ALU_OUT;
  logic       ALU_OUT_VALID;
  logic       TX_BUSY = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       FRAME_ERR;

  int n_assert = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int err_cnt  = 0;
  int tx_cnt   = 0;
  logic prev_en = 1'b0;
  logic alu_mute = 1'b0;

  alu_cmd_ctrl #(.DATA_WIDTH(8), .FUN_WIDTH(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .TX_BUSY(TX_BUSY),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Registered model ALU with one-cycle latency: add, sub, mul, div.
  always @(posedge CLK) begin
    if (!RST) begin
      ALU_OUT       <= 8'h00;
      ALU_OUT_VALID <= 1'b0;
    end else begin
      ALU_OUT_VALID <= ALU_EN & ~alu_mute;
      case (ALU_FUN)
        4'd0:    ALU_OUT <= ALU_A + ALU_B;
        4'd1:    ALU_OUT <= ALU_A - ALU_B;
        4'd2:    ALU_OUT <= ALU_A * ALU_B;
        4'd3:    ALU_OUT <= (ALU_B != 0) ? ALU_A / ALU_B : 8'h00;
        default: ALU_OUT <= 8'h00;
      endcase
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    if (ALU_EN === 1'b1)    en_cnt++;
    if (FRAME_ERR === 1'b1) err_cnt++;
    if (TX_D_VLD === 1'b1)  tx_cnt++;
    n_assert++;
    if (ALU_EN === 1'b1 && prev_en === 1'b1) begin
      n_fail++;
      $display("FAIL alu_en_consecutive: ALU_EN high two cycles in a row at %0t", $time);
    end
    n_assert++;
    if (TX_D_VLD === 1'b1 && TX_BUSY === 1'b1) begin
      n_fail++;
      $display("FAIL tx_vld_while_busy: TX_D_VLD=1 with TX_BUSY=1 at %0t", $time);
    end
    prev_en = ALU_EN;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    send_byte(8'hCC);
    send_byte(a);
    send_byte(b);
    send_byte(f);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    step();
    step();
    n_assert++;
    if ({ALU_A, ALU_B, ALU_FUN, TX_P_DATA, ALU_EN, TX_D_VLD, FRAME_ERR} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got A=%h B=%h F=%h TX=%h EN=%b TV=%b FE=%b, want all 0",
               ALU_A, ALU_B, ALU_FUN, TX_P_DATA, ALU_EN, TX_D_VLD, FRAME_ERR);
    end
    RST = 1'b1;
    step();
  endtask

  task automatic test_add();
    int e0, t0, f0;
    e0 = en_cnt; t0 = tx_cnt; f0 = err_cnt;
    send_frame(8'h05, 8'h03, 8'h00);
    n_assert++;
    if (ALU_A !== 8'h05 || ALU_B !== 8'h03 || ALU_FUN !== 4'h0 || ALU_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL add_operands: got A=%h B=%h F=%h EN=%b, want 05 03 0 1", ALU_A, ALU_B, ALU_FUN, ALU_EN);
    end
    step();
    n_assert++;
    if (ALU_EN !== 1'b0 || TX_D_VLD !== 1'b0) begin
      n_fail++;
      $display("FAIL add_n2: got EN=%b TV=%b, want 0 0", ALU_EN, TX_D_VLD);
    end
    step();
    n_assert++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h08) begin
      n_fail++;
      $display("FAIL add_result: got TV=%b TX=%h, want 1 08", TX_D_VLD, TX_P_DATA);
    end
    step();
    step();
    n_assert++;
    if (en_cnt - e0 !== 1 || tx_cnt - t0 !== 1 || err_cnt - f0 !== 0) begin
      n_fail++;
      $display("FAIL add_pulse_counts: got en=%0d tx=%0d err=%0d, want 1 1 0",
               en_cnt - e0, tx_cnt - t0, err_cnt - f0);
    end
  endtask

  task automatic test_bad_frames();
    int e0, f0;
    e0 = en_cnt; f0 = err_cnt;
    send_byte(8'h55);
    n_assert++;
    if (FRAME_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_header_err: got FRAME_ERR=%b, want 1", FRAME_ERR);
    end
    step();
    n_assert++;
    if (FRAME_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_header_pulse_width: got FRAME_ERR=%b, want 0", FRAME_ERR);
    end
    send_frame(8'h10, 8'h02, 8'h1F);
    n_assert++;
    if (FRAME_ERR !== 1'b1 || ALU_EN !== 1'b0 || ALU_FUN !== 4'h0 || ALU_A !== 8'h10) begin
      n_fail++;
      $display("FAIL bad_fun: got FE=%b EN=%b F=%h A=%h, want 1 0 0 10", FRAME_ERR, ALU_EN, ALU_FUN, ALU_A);
    end
    step();
    step();
    step();
    n_assert++;
    if (en_cnt - e0 !== 0 || err_cnt - f0 !== 2) begin
      n_fail++;
      $display("FAIL bad_counts: got en=%0d err=%0d, want 0 2", en_cnt - e0, err_cnt - f0);
    end
  endtask

  task automatic test_back_pressure();
    int t0;
    int bad;
    t0 = tx_cnt;
    bad = 0;
    TX_BUSY = 1'b1;
    send_frame(8'h0C, 8'h04, 8'h03);
    step();
    step();
    n_assert++;
    if (TX_P_DATA !== 8'h03 || TX_D_VLD !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_capture: got TX=%h TV=%b, want 03 0", TX_P_DATA, TX_D_VLD);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (TX_P_DATA !== 8'h03 || TX_D_VLD !== 1'b0) bad++;
    end
    n_assert++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold: got %0d bad cycles, want 0", bad);
    end
    TX_BUSY = 1'b0;
    step();
    n_assert++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h03) begin
      n_fail++;
      $display("FAIL bp_release: got TV=%b TX=%h, want 1 03", TX_D_VLD, TX_P_DATA);
    end
    step();
    step();
    n_assert++;
    if (tx_cnt - t0 !== 1) begin
      n_fail++;
      $display("FAIL bp_once: got %0d TX pulses, want 1", tx_cnt - t0);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int k;
    t0 = tx_cnt;
    k = 0;
    alu_mute = 1'b1;
    send_frame(8'h01, 8'h02, 8'h00);
    n_assert++;
    if (ALU_EN !== 1'b1) begin
      n_fail++;
      $display("FAIL to_en: got ALU_EN=%b, want 1", ALU_EN);
    end
    while (k < 30) begin
      step();
      k++;
      if (FRAME_ERR === 1'b1) break;
    end
    n_assert++;
    if (k !== 9) begin
      n_fail++;
      $display("FAIL to_latency: got FRAME_ERR %0d cycles after ALU_EN, want 9", k);
    end
    alu_mute = 1'b0;
    step();
    step();
    n_assert++;
    if (tx_cnt - t0 !== 0) begin
      n_fail++;
      $display("FAIL to_no_tx: got %0d TX pulses, want 0", tx_cnt - t0);
    end
    send_frame(8'h07, 8'h02, 8'h01);
    step();
    step();
    n_assert++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h05) begin
      n_fail++;
      $display("FAIL to_recover: got TV=%b TX=%h, want 1 05", TX_D_VLD, TX_P_DATA);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int t0;
    send_byte(8'hCC);
    send_byte(8'hAA);
    RST = 1'b0;
    step();
    n_assert++;
    if ({ALU_A, ALU_B, ALU_FUN, TX_P_DATA, ALU_EN, TX_D_VLD, FRAME_ERR} !== 31'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got A=%h B=%h F=%h TX=%h EN=%b TV=%b FE=%b, want all 0",
               ALU_A, ALU_B, ALU_FUN, TX_P_DATA, ALU_EN, TX_D_VLD, FRAME_ERR);
    end
    RST = 1'b1;
    step();
    t0 = tx_cnt;
    send_byte(8'h33);
    n_assert++;
    if (FRAME_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_discard: got FRAME_ERR=%b, want 1", FRAME_ERR);
    end
    send_frame(8'h09, 8'h04, 8'h01);
    step();
    step();
    n_assert++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h05 || tx_cnt - t0 !== 1) begin
      n_fail++;
      $display("FAIL mid_reset_frame: got TV=%b TX=%h pulses=%0d, want 1 05 1",
               TX_D_VLD, TX_P_DATA, tx_cnt - t0);
    end
    step();
  endtask

  task automatic test_drop();
    int f0;
    send_frame(8'h06, 8'h02, 8'h02);
    f0 = err_cnt;
    step();
    RX_P_DATA = 8'hCC;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
    n_assert++;
    if (FRAME_ERR !== 1'b1 || TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h0C) begin
      n_fail++;
      $display("FAIL drop_wait: got FE=%b TV=%b TX=%h, want 1 1 0C", FRAME_ERR, TX_D_VLD, TX_P_DATA);
    end
    step();
    step();
    n_assert++;
    if (err_cnt - f0 !== 1 || FRAME_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_count: got err=%0d FE=%b, want 1 0", err_cnt - f0, FRAME_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bad_frames();
    test_back_pressure();
    test_timeout();
    test_reset_mid();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
